// File: rtl/bp_fe_cmd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_fe_cmd_pkg: front-end command layout, opcodes and sequencer states.
// Revision: 1.0
// ---------------------------------------------------------------------------
package bp_fe_cmd_pkg;

   localparam int opcode_width_gp   = 3;
   localparam int vaddr_width_gp    = 39;
   localparam int operands_width_gp = 72;
   localparam int vtag_width_gp     = 27;

   typedef enum logic [2:0] {
      e_op_pc_redirect  = 3'd0,
      e_op_state_reset  = 3'd1,
      e_op_itlb_fill    = 3'd2,
      e_op_icache_fence = 3'd3
   } bp_fe_cmd_op_e;

   // Opcode kept as raw bits so undefined encodings survive the cast.
   typedef struct packed {
      logic [operands_width_gp-1:0] operands;
      logic [vaddr_width_gp-1:0]    vaddr;
      logic [opcode_width_gp-1:0]   opcode;
   } bp_fe_cmd_s;

   typedef enum logic [1:0] {
      e_idle  = 2'd0,
      e_flush = 2'd1,
      e_fence = 2'd2
   } bp_fe_state_e;

   function automatic logic [vtag_width_gp-1:0] vtag_of(input logic [vaddr_width_gp-1:0] vaddr);
      return vaddr[vaddr_width_gp-1:12];
   endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_counter_clear_up.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bsg_counter_clear_up: wrapping up-counter with synchronous clear.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bsg_counter_clear_up #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               clear_i,
   input  logic               up_i,
   output logic [width_p-1:0] count_o
);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_o <= '0;
      end else if (clear_i) begin
         count_o <= '0;
      end else if (up_i) begin
         count_o <= count_o + width_p'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/bp_fe_cmd_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_fe_cmd_sequencer: pops fe_cmds and sequences redirects, ITLB fills, fences.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bp_fe_cmd_sequencer
   import bp_fe_cmd_pkg::*;
#(
   parameter int flush_cycles_p = 2,
   parameter int vaddr_width_p  = 39
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic [113:0]                 fe_cmd_i,
   input  logic                         fe_cmd_v_i,
   output logic                         fe_cmd_yumi_o,
   output logic                         redirect_v_o,
   output logic [vaddr_width_p-1:0]     redirect_pc_o,
   output logic                         itlb_flush_o,
   output logic                         itlb_w_v_o,
   output logic [vtag_width_gp-1:0]     itlb_w_vtag_o,
   output logic [operands_width_gp-1:0] itlb_w_entry_o,
   output logic                         fence_req_o,
   input  logic                         fence_done_i,
   output logic                         fetch_stall_o,
   output logic                         illegal_cmd_o,
   output logic [15:0]                  cmd_count_o
);

   localparam int flush_cnt_width_lp = (flush_cycles_p > 1) ? $clog2(flush_cycles_p) : 1;
   localparam logic [flush_cnt_width_lp-1:0] flush_init_lp = flush_cnt_width_lp'(flush_cycles_p - 1);

   bp_fe_cmd_s                   cmd;
   bp_fe_state_e                 state_q;
   logic [flush_cnt_width_lp-1:0] flush_cnt_q;
   logic                         redirect_v_q;
   logic [vaddr_width_p-1:0]     redirect_pc_q;
   logic                         itlb_flush_q;
   logic                         itlb_w_v_q;
   logic [vtag_width_gp-1:0]     itlb_w_vtag_q;
   logic [operands_width_gp-1:0] itlb_w_entry_q;
   logic                         fence_req_q;
   logic                         fetch_stall_q;
   logic                         illegal_q;

   assign cmd = fe_cmd_i;

   // Reset gates the pop so nothing leaves the queue while reset is held.
   assign fe_cmd_yumi_o = reset_n_i & fe_cmd_v_i & (state_q == e_idle);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q        <= e_idle;
         flush_cnt_q    <= '0;
         redirect_v_q   <= 1'b0;
         redirect_pc_q  <= '0;
         itlb_flush_q   <= 1'b0;
         itlb_w_v_q     <= 1'b0;
         itlb_w_vtag_q  <= '0;
         itlb_w_entry_q <= '0;
         fence_req_q    <= 1'b0;
         fetch_stall_q  <= 1'b0;
         illegal_q      <= 1'b0;
      end else begin
         redirect_v_q <= 1'b0;
         itlb_flush_q <= 1'b0;
         itlb_w_v_q   <= 1'b0;
         illegal_q    <= 1'b0;
         unique case (state_q)
            e_idle: begin
               if (fe_cmd_yumi_o) begin
                  case (cmd.opcode)
                     e_op_pc_redirect, e_op_state_reset: begin
                        redirect_v_q  <= 1'b1;
                        redirect_pc_q <= cmd.vaddr[vaddr_width_p-1:0];
                        itlb_flush_q  <= (cmd.opcode == e_op_state_reset);
                        flush_cnt_q   <= flush_init_lp;
                        fetch_stall_q <= 1'b1;
                        state_q       <= e_flush;
                     end
                     e_op_itlb_fill: begin
                        itlb_w_v_q     <= 1'b1;
                        itlb_w_vtag_q  <= vtag_of(cmd.vaddr);
                        itlb_w_entry_q <= cmd.operands;
                     end
                     e_op_icache_fence: begin
                        fence_req_q   <= 1'b1;
                        fetch_stall_q <= 1'b1;
                        state_q       <= e_fence;
                     end
                     default: illegal_q <= 1'b1;
                  endcase
               end
            end
            e_flush: begin
               if (flush_cnt_q == '0) begin
                  fetch_stall_q <= 1'b0;
                  state_q       <= e_idle;
               end else begin
                  flush_cnt_q <= flush_cnt_q - flush_cnt_width_lp'(1);
               end
            end
            e_fence: begin
               if (fence_done_i) begin
                  fence_req_q   <= 1'b0;
                  fetch_stall_q <= 1'b0;
                  state_q       <= e_idle;
               end
            end
            default: begin
               fence_req_q   <= 1'b0;
               fetch_stall_q <= 1'b0;
               state_q       <= e_idle;
            end
         endcase
      end
   end

   bsg_counter_clear_up #(
      .width_p (16)
   ) u_cmd_count (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (1'b0),
      .up_i      (fe_cmd_yumi_o),
      .count_o   (cmd_count_o)
   );

   assign redirect_v_o   = redirect_v_q;
   assign redirect_pc_o  = redirect_pc_q;
   assign itlb_flush_o   = itlb_flush_q;
   assign itlb_w_v_o     = itlb_w_v_q;
   assign itlb_w_vtag_o  = itlb_w_vtag_q;
   assign itlb_w_entry_o = itlb_w_entry_q;
   assign fence_req_o    = fence_req_q;
   assign fetch_stall_o  = fetch_stall_q;
   assign illegal_cmd_o  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_cmd_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bp_fe_cmd_sequencer: directed self-checking bench for bp_fe_cmd_sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bp_fe_cmd_sequencer;

   logic         clk_i;
   logic         reset_n_i;
   logic [113:0] fe_cmd_i;
   logic         fe_cmd_v_i;
   logic         fe_cmd_yumi_o;
   logic         redirect_v_o;
   logic [38:0]  redirect_pc_o;
   logic         itlb_flush_o;
   logic         itlb_w_v_o;
   logic [26:0]  itlb_w_vtag_o;
   logic [71:0]  itlb_w_entry_o;
   logic         fence_req_o;
   logic         fence_done_i;
   logic         fetch_stall_o;
   logic         illegal_cmd_o;
   logic [15:0]  cmd_count_o;

   int n_total = 0;
   int n_bad   = 0;

   bp_fe_cmd_sequencer #(
      .flush_cycles_p (2),
      .vaddr_width_p  (39)
   ) dut (
      .clk_i          (clk_i),
      .reset_n_i      (reset_n_i),
      .fe_cmd_i       (fe_cmd_i),
      .fe_cmd_v_i     (fe_cmd_v_i),
      .fe_cmd_yumi_o  (fe_cmd_yumi_o),
      .redirect_v_o   (redirect_v_o),
      .redirect_pc_o  (redirect_pc_o),
      .itlb_flush_o   (itlb_flush_o),
      .itlb_w_v_o     (itlb_w_v_o),
      .itlb_w_vtag_o  (itlb_w_vtag_o),
      .itlb_w_entry_o (itlb_w_entry_o),
      .fence_req_o    (fence_req_o),
      .fence_done_i   (fence_done_i),
      .fetch_stall_o  (fetch_stall_o),
      .illegal_cmd_o  (illegal_cmd_o),
      .cmd_count_o    (cmd_count_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [113:0] mk(input logic [2:0] op, input logic [38:0] va, input logic [71:0] opnd);
      return {opnd, va, op};
   endfunction

   initial begin
      reset_n_i    = 1'b0;
      fe_cmd_v_i   = 1'b0;
      fe_cmd_i     = '0;
      fence_done_i = 1'b0;
      #2;
      check("rst_stall", fetch_stall_o, 0);
      check("rst_fence", fence_req_o, 0);
      check("rst_pc", redirect_pc_o, 0);
      check("rst_count", cmd_count_o, 0);
      tick();
      tick();
      reset_n_i = 1'b1;

      // pc_redirect: stall T+1..T+2, next pop at T+3
      fe_cmd_v_i = 1'b1;
      fe_cmd_i   = mk(3'd0, 39'h00_8000_0040, 72'h0);
      #1 check("redir_yumi", fe_cmd_yumi_o, 1);
      tick();
      fe_cmd_i = mk(3'd6, 39'h0, 72'h0);
      check("redir_v", redirect_v_o, 1);
      check("redir_pc", redirect_pc_o, 39'h0080000040);
      check("redir_stall1", fetch_stall_o, 1);
      check("redir_noyumi1", fe_cmd_yumi_o, 0);
      tick();
      check("redir_v_off", redirect_v_o, 0);
      check("redir_stall2", fetch_stall_o, 1);
      check("redir_noyumi2", fe_cmd_yumi_o, 0);
      tick();
      check("redir_stall3", fetch_stall_o, 0);
      check("redir_pc_hold", redirect_pc_o, 39'h0080000040);
      check("ill_yumi", fe_cmd_yumi_o, 1);
      tick();

      // illegal opcode 6 popped; next command popped at T+1
      check("ill_pulse", illegal_cmd_o, 1);
      check("ill_noredir", redirect_v_o, 0);
      check("ill_noitlb", itlb_w_v_o, 0);
      check("ill_nofence", fence_req_o, 0);
      check("ill_count", cmd_count_o, 2);

      // four back-to-back itlb fills
      for (int k = 1; k <= 4; k++) begin
         fe_cmd_i = mk(3'd2, 39'(32'h1000 * k), {64'hA5A5_0000_0000_0000, 8'(k)});
         #1 check("fill_yumi", fe_cmd_yumi_o, 1);
         check("fill_stall", fetch_stall_o, 0);
         if (k > 1) begin
            check("fill_wv", itlb_w_v_o, 1);
            check("fill_vtag", itlb_w_vtag_o, k - 1);
         end
         tick();
         if (k == 1) check("ill_pulse_off", illegal_cmd_o, 0);
      end
      fe_cmd_v_i = 1'b0;
      check("fill_wv4", itlb_w_v_o, 1);
      check("fill_vtag4", itlb_w_vtag_o, 4);
      check("fill_entry4", itlb_w_entry_o, 72'hA5A5_0000_0000_0000_04);
      tick();
      check("fill_wv_off", itlb_w_v_o, 0);
      check("fill_count", cmd_count_o, 6);

      // icache fence, done 5 cycles after req rises
      fe_cmd_v_i = 1'b1;
      fe_cmd_i   = mk(3'd3, 39'h0, 72'h0);
      #1 check("fence_yumi", fe_cmd_yumi_o, 1);
      tick();
      fe_cmd_i = mk(3'd7, 39'h0, 72'h0);
      for (int i = 1; i <= 6; i++) begin
         check("fence_req", fence_req_o, 1);
         check("fence_stall", fetch_stall_o, 1);
         check("fence_noyumi", fe_cmd_yumi_o, 0);
         if (i == 6) fence_done_i = 1'b1;
         tick();
      end
      fence_done_i = 1'b0;
      check("fence_req_off", fence_req_o, 0);
      check("fence_stall_off", fetch_stall_o, 0);
      check("fence_repop", fe_cmd_yumi_o, 1);
      tick();
      fe_cmd_v_i = 1'b0;
      check("fence_ill", illegal_cmd_o, 1);
      check("fence_count", cmd_count_o, 8);

      // state_reset: redirect plus itlb flush pulse
      fe_cmd_v_i = 1'b1;
      fe_cmd_i   = mk(3'd1, 39'h12_3456_7000, 72'h0);
      tick();
      fe_cmd_v_i = 1'b0;
      check("sr_flush", itlb_flush_o, 1);
      check("sr_redir", redirect_v_o, 1);
      check("sr_pc", redirect_pc_o, 39'h1234567000);
      tick();
      check("sr_flush_off", itlb_flush_o, 0);
      tick();

      // reset during fence
      fe_cmd_v_i = 1'b1;
      fe_cmd_i   = mk(3'd3, 39'h0, 72'h0);
      tick();
      check("rf_req", fence_req_o, 1);
      reset_n_i = 1'b0;
      #1;
      check("rf_req_drop", fence_req_o, 0);
      check("rf_stall_drop", fetch_stall_o, 0);
      check("rf_count", cmd_count_o, 0);
      check("rf_noyumi", fe_cmd_yumi_o, 0);
      tick();
      check("rf_noyumi_edge", cmd_count_o, 0);
      reset_n_i = 1'b1;
      fe_cmd_i  = mk(3'd0, 39'h00_0000_2000, 72'h0);
      #1 check("rf_after_yumi", fe_cmd_yumi_o, 1);
      tick();
      fe_cmd_v_i = 1'b0;
      check("rf_after_redir", redirect_v_o, 1);
      check("rf_after_pc", redirect_pc_o, 39'h2000);

      // reset during flush
      check("rl_stall", fetch_stall_o, 1);
      reset_n_i = 1'b0;
      #1;
      check("rl_stall_drop", fetch_stall_o, 0);
      check("rl_redir_drop", redirect_v_o, 0);
      check("rl_pc_drop", redirect_pc_o, 0);
      tick();
      reset_n_i  = 1'b1;
      fe_cmd_v_i = 1'b1;
      fe_cmd_i   = mk(3'd2, 39'h00_0000_9000, 72'h77);
      tick();
      fe_cmd_v_i = 1'b0;
      check("rl_after_wv", itlb_w_v_o, 1);
      check("rl_after_vtag", itlb_w_vtag_o, 9);
      check("rl_after_count", cmd_count_o, 1);

      // counter wrap
      reset_n_i = 1'b0;
      tick();
      reset_n_i  = 1'b1;
      fe_cmd_v_i = 1'b1;
      fe_cmd_i   = mk(3'd7, 39'h0, 72'h0);
      repeat (65535) @(posedge clk_i);
      #1;
      fe_cmd_v_i = 1'b0;
      check("wrap_ffff", cmd_count_o, 16'hFFFF);
      fe_cmd_v_i = 1'b1;
      fe_cmd_i   = mk(3'd2, 39'h00_0000_1000, 72'h1);
      tick();
      fe_cmd_v_i = 1'b0;
      check("wrap_zero", cmd_count_o, 16'h0000);
      check("wrap_wv", itlb_w_v_o, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bp_fe_cmd_sequencer.md
# bp_fe_cmd_sequencer

Downstream consumer of the front-end command queue. Pops one 114-bit fe_cmd at a time with a valid/yumi handshake, decodes its opcode, and sequences the resulting front-end actions: PC redirects with a fetch-flush window, ITLB fills, and I-cache fences that wait for completion. While a multi-cycle command is in progress it holds fetch stalled and stops popping the queue.

## Interface
Parameters:
- flush_cycles_p, 2: cycles fetch stays stalled after a redirect or state reset; legal range is 1 or more.
- vaddr_width_p, 39: virtual address width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; asynchronous, active-low.
- fe_cmd_i  in  114  command from the queue head.
- fe_cmd_v_i  in  1  queue head valid.
- fe_cmd_yumi_o  out  1  pop; the command is consumed this cycle.
- redirect_v_o  out  1  one-cycle redirect pulse.
- redirect_pc_o  out  vaddr_width_p  redirect target; held between redirects.
- itlb_flush_o  out  1  one-cycle pulse, state reset only.
- itlb_w_v_o  out  1  one-cycle ITLB write pulse.
- itlb_w_vtag_o  out  27  ITLB write vtag, which is vaddr[38:12].
- itlb_w_entry_o  out  72  ITLB entry payload.
- fence_req_o  out  1  I-cache fence request; level signal.
- fence_done_i  in  1  fence completion.
- fetch_stall_o  out  1  high whenever the FSM is not idle.
- illegal_cmd_o  out  1  one-cycle pulse for an undefined opcode.
- cmd_count_o  out  16  count of commands consumed; wraps.

## Operation
fe_cmd field layout:
- opcode = [2:0]
- vaddr = [41:3]
- operands = [113:42]

Opcode encodings:
- 0: pc_redirect
- 1: state_reset
- 2: itlb_fill
- 3: icache_fence
- 4–7: illegal

FSM states:
- e_idle: fe_cmd_yumi_o = fe_cmd_v_i. This is combinational, and yumi is asserted only in this state.
- e_flush: a down-counter is loaded with flush_cycles_p − 1. Exit to e_idle when the count is 0.
- e_fence: fence_req_o is high. Exit to e_idle in the cycle after fence_done_i is sampled high.

Actions for a command consumed in cycle T. All outputs are registered and appear at T+1.
- pc_redirect: redirect_v_o=1, redirect_pc_o=vaddr, next state e_flush.
- state_reset: same as pc_redirect, plus itlb_flush_o=1.
- itlb_fill: itlb_w_v_o=1, vtag=vaddr[38:12], entry=operands. Stay in e_idle, so a new command can be popped at T+1.
- icache_fence: next state e_fence, fence_req_o=1 from T+1.
- illegal: illegal_cmd_o=1. Stay in e_idle.

cmd_count_o increments by 1 on every yumi, modulo 2^16.

Reset values (all outputs 0, state e_idle):
- state = e_idle
- fetch_stall_o = 0
- fence_req_o = 0
- all pulse outputs = 0
- redirect_pc_o = 0
- cmd_count_o = 0
- flush counter = 0

## Timing
- Latency from yumi to action is exactly 1 cycle. The head-of-queue data is captured on the yumi edge.
- fe_cmd_i is don't-care when fe_cmd_v_i=0.
- Valid and yumi follow bsg rules: yumi never rises without valid, and there is no combinational path from yumi back to valid.
- Redirect stall window: fetch_stall_o is high for cycles T+1 through T+flush_cycles_p. The next pop can happen no earlier than T+flush_cycles_p+1.
- Fence timing: fence_req_o rises at T+1 and stays high through the cycle in which fence_done_i=1. It is low, with the FSM in e_idle, the cycle after. If done arrives at T+1, the fence lasts 1 cycle.
- fence_done_i is ignored outside e_fence.
- Back-to-back itlb_fill or illegal commands sustain 1 pop per cycle.
- Reset mid-operation: assertion of reset_n_i immediately forces all outputs to their reset values, asynchronously. An in-flight fence or flush is abandoned. Commands still in the queue are not popped until reset deasserts and a clock edge occurs.
- cmd_count_o wraps from 16'hFFFF to 16'h0000.

## Structure
Package bp_fe_cmd_pkg holds:
- the opcode enum (bp_fe_cmd_op_e)
- the packed command struct (bp_fe_cmd_s)
- field width localparams: 3, 39, 72, 27
- the FSM state enum

The one natural sub-module is bsg_counter_clear_up. It is instantiated for cmd_count_o. The flush down-counter stays inline. Decoding stays inline.

## Test plan
- Reset, then a pc_redirect with vaddr=39'h00_8000_0040 and flush_cycles_p=2. Required: yumi for 1 cycle; redirect_v_o=1 and redirect_pc_o=39'h0080000040 at T+1; fetch_stall_o high for T+1 and T+2; next yumi at T+3.
- Four back-to-back itlb_fill commands with vaddr=0x1000·k. Required: 4 consecutive yumis; itlb_w_v_o high 4 consecutive cycles with vtags 1, 2, 3, 4; fetch_stall_o stays 0; cmd_count_o=4.
- icache_fence, fence_done_i asserted 5 cycles after fence_req_o rises. Required: fence_req_o high for 6 cycles; no yumi in that window; idle and popping again in the following cycle.
- Opcode 3'd6. Required: illegal_cmd_o pulses once at T+1; no redirect, ITLB, or fence activity; the next command is popped at T+1.
- Reset asserted during e_fence and during e_flush. Required: fence_req_o and fetch_stall_o drop to 0 with no clock edge; cmd_count_o=0; first command after release is handled normally.
- Preload cmd_count_o to 16'hFFFF by running 65535 illegal commands, then issue one more command. Required: cmd_count_o=16'h0000.
